// File: rtl/kbd_pkg.sv
// kbd_pkg: shared definitions for the 4x4 keypad scanner.
//   state_t       scan/debounce FSM encoding
//   KEY_LSB, VALID_BIT, OVR_BIT   field positions inside the CPU data word
//   ROW_RESET     row drive after reset (row 0 low)
//   COL_IDLE      column pattern with no key pressed
//   lowest_low()  index of the lowest-numbered low bit of a column pattern
package kbd_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HOLD      = 2'd2
    } state_t;

    localparam int KEY_LSB   = 0;
    localparam int VALID_BIT = 8;
    localparam int OVR_BIT   = 9;

    localparam logic [3:0] ROW_RESET = 4'b1110;
    localparam logic [3:0] COL_IDLE  = 4'hF;

    // Multi-key presses within one row resolve to the lowest column.
    function automatic logic [1:0] lowest_low(input logic [3:0] pat);
        if (!pat[0])      return 2'd0;
        else if (!pat[1]) return 2'd1;
        else if (!pat[2]) return 2'd2;
        else              return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// keypad_col_sync: generic two-flop synchronizer for asynchronous inputs.
//   clk    in   system clock
//   reset  in   synchronous active-high reset, loads RESET_VAL into both stages
//   d      in   asynchronous input bus
//   q      out  synchronized bus, two clk cycles of latency
module keypad_col_sync #(
    parameter int                 WIDTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan4x4.sv
// keypad_scan4x4: scans a 4x4 active-low matrix keypad, debounces each press
// and release, and presents the hex key code as a CPU-readable data word.
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   cs       in   CPU read strobe; one high cycle acknowledges the current key
//   i_col    in   keypad columns, active-low, asynchronous
//   o_row    out  keypad row drives, active-low, exactly one bit low
//   o_data   out  {22'b0, overrun, valid, 4'b0, key[3:0]}
//   o_valid  out  copy of o_data[VALID_BIT] for interrupt/poll use
//
// Handshake: a commit sets valid; cs high for one cycle clears valid and
// overrun on the next edge. If cs and a commit land in the same cycle, the
// commit wins and overrun is left clear because the old key was read.
// A commit while valid is still set (and no cs) flags overrun.
module keypad_scan4x4
    import kbd_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [3:0]  i_col,
    output logic [3:0]  o_row,
    output logic [31:0] o_data,
    output logic        o_valid
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_CNT);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

    logic [3:0] col_s;

    keypad_col_sync #(
        .WIDTH     (4),
        .RESET_VAL (COL_IDLE)
    ) u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d     (i_col),
        .q     (col_s)
    );

    // FSM state is kept as a plain named signal so checkers can bind to it.
    state_t            state, state_nx;
    logic [SCAN_W-1:0] scan_cnt, scan_cnt_nx;
    logic [DEB_W-1:0]  deb_cnt, deb_cnt_nx;
    logic [1:0]        row_idx, row_idx_nx;
    logic [3:0]        pat, pat_nx;
    logic              commit;
    logic [3:0]        code;

    logic [3:0]        key_r;
    logic              valid_r;
    logic              ovr_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SCAN;
            scan_cnt <= '0;
            deb_cnt  <= '0;
            row_idx  <= 2'd0;
            pat      <= COL_IDLE;
        end else begin
            state    <= state_nx;
            scan_cnt <= scan_cnt_nx;
            deb_cnt  <= deb_cnt_nx;
            row_idx  <= row_idx_nx;
            pat      <= pat_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        scan_cnt_nx = scan_cnt;
        deb_cnt_nx  = deb_cnt;
        row_idx_nx  = row_idx;
        pat_nx      = pat;
        commit      = 1'b0;

        case (state)
            SCAN: begin
                if (scan_cnt == SCAN_LAST) begin
                    // Columns are looked at only at the end of a row window,
                    // so the drive and the synchronizer have had time to settle.
                    scan_cnt_nx = '0;
                    if (col_s != COL_IDLE) begin
                        pat_nx     = col_s;
                        deb_cnt_nx = '0;
                        state_nx   = DEB_PRESS;
                    end else begin
                        row_idx_nx = row_idx + 2'd1;
                    end
                end else begin
                    scan_cnt_nx = scan_cnt + SCAN_W'(1);
                end
            end

            DEB_PRESS: begin
                if (col_s != pat) begin
                    state_nx    = SCAN;
                    scan_cnt_nx = '0;
                    deb_cnt_nx  = '0;
                    row_idx_nx  = row_idx + 2'd1;
                end else if (deb_cnt == DEB_LAST) begin
                    commit     = 1'b1;
                    deb_cnt_nx = '0;
                    state_nx   = HOLD;
                end else begin
                    deb_cnt_nx = deb_cnt + DEB_W'(1);
                end
            end

            HOLD: begin
                // Row stays held; only a full idle run on this row ends the press.
                if (col_s != COL_IDLE) begin
                    deb_cnt_nx = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nx    = SCAN;
                    scan_cnt_nx = '0;
                    deb_cnt_nx  = '0;
                    row_idx_nx  = row_idx + 2'd1;
                end else begin
                    deb_cnt_nx = deb_cnt + DEB_W'(1);
                end
            end

            default: begin
                state_nx    = SCAN;
                scan_cnt_nx = '0;
                deb_cnt_nx  = '0;
            end
        endcase
    end

    // The row index is frozen outside SCAN, so it is the row of the press.
    assign code = {row_idx, lowest_low(pat)};

    always_ff @(posedge clk) begin
        if (reset) begin
            key_r   <= 4'h0;
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
        end else if (commit) begin
            key_r   <= code;
            valid_r <= 1'b1;
            ovr_r   <= valid_r & ~cs;
        end else if (cs) begin
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
        end
    end

    always_comb begin
        o_data                  = '0;
        o_data[KEY_LSB +: 4]    = key_r;
        o_data[VALID_BIT]       = valid_r;
        o_data[OVR_BIT]         = ovr_r;
    end

    assign o_valid = valid_r;
    assign o_row   = ~(4'b0001 << row_idx);

endmodule

// File: tb/tb_keypad_scan4x4.sv
// tb_keypad_scan4x4: self-checking bench for keypad_scan4x4 with
// SCAN_DIV=4 and DEBOUNCE_CNT=8. A behavioural keypad drives i_col from o_row;
// every expected commit word is queued before the press and compared when
// the DUT raises a new valid word.
module tb_keypad_scan4x4;

    logic        clk;
    logic        reset;
    logic        cs;
    logic [3:0]  i_col;
    logic [3:0]  o_row;
    logic [31:0] o_data;
    logic        o_valid;

    keypad_scan4x4 #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .i_col   (i_col),
        .o_row   (o_row),
        .o_data  (o_data),
        .o_valid (o_valid)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- keypad model ----------------
    logic       press_on;
    logic [1:0] press_row;
    logic [1:0] press_col;
    logic       bounce_hi;

    assign i_col = (press_on && !bounce_hi && !o_row[press_row])
                   ? ~(4'b0001 << press_col) : 4'hF;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          n_cmp;
    int          n_err;
    int          commit_cnt;
    logic [31:0] prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    // A new word with valid set is a commit.
    always @(negedge clk) begin
        if (!reset && o_data !== prev_data && o_data[8] === 1'b1) begin
            commit_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_commit: got %h expected none", o_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("commit_data", o_data, e);
                check("commit_valid", {31'b0, o_valid}, {31'b0, e[8]});
            end
        end
        prev_data = o_data;
    end

    // ---------------- driver tasks ----------------
    task automatic press(input logic [1:0] r, input logic [1:0] c);
        press_row = r;
        press_col = c;
        bounce_hi = 1'b0;
        press_on  = 1'b1;
    endtask

    task automatic release_key();
        press_on = 1'b0;
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic wait_row(input logic [3:0] target, input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (o_row !== target && k < 100);
        if (o_row !== target) fail_now(name);
    endtask

    task automatic wait_commit(input int start, input string name);
        int k;
        k = 0;
        while (commit_cnt == start && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (commit_cnt == start) fail_now(name);
    endtask

    task automatic cs_pulse();
        @(posedge clk);
        #1 cs = 1'b1;
        @(posedge clk);
        #1 cs = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  row;
        logic [1:0]  col;
        logic [31:0] exp_commit;
        logic [31:0] exp_ack;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int          start;
        int          lat;
        logic [3:0]  one;
        logic [3:0]  exp_row;

        vecs[0] = '{row: 2'd0, col: 2'd0, exp_commit: 32'h0000_0100, exp_ack: 32'h0000_0000};
        vecs[1] = '{row: 2'd3, col: 2'd3, exp_commit: 32'h0000_010F, exp_ack: 32'h0000_000F};
        vecs[2] = '{row: 2'd1, col: 2'd2, exp_commit: 32'h0000_0106, exp_ack: 32'h0000_0006};
        vecs[3] = '{row: 2'd2, col: 2'd3, exp_commit: 32'h0000_010B, exp_ack: 32'h0000_000B};

        n_cmp      = 0;
        n_err      = 0;
        commit_cnt = 0;
        prev_data  = 32'h0;
        reset      = 1'b1;
        cs         = 1'b0;
        press_on   = 1'b0;
        press_row  = 2'd0;
        press_col  = 2'd0;
        bounce_hi  = 1'b0;
        one        = 4'b0001;

        // ---- reset state and idle row walk ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_row", {28'b0, o_row}, 32'h0000_000E);
        check("reset_data", o_data, 32'h0);
        check("reset_valid", {31'b0, o_valid}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            exp_row = ~(one << ((k / 4) % 4));
            check("walk_row", {28'b0, o_row}, {28'b0, exp_row});
            check("walk_data", o_data, 32'h0);
        end

        // ---- stable key at row 2 col 1 ----
        press(2'd2, 2'd1);
        exp_q.push_back(32'h0000_0109);
        start = commit_cnt;
        wait_row(4'b1011, "row2_reach");
        lat = 0;
        while (commit_cnt == start && lat < 100) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check("key9_latency_ok", {31'b0, (lat >= 11 && lat <= 14)}, 32'h1);
        if (!(lat >= 11 && lat <= 14)) $display("  latency was %0d cycles", lat);
        check("key9_row_frozen", {28'b0, o_row}, 32'h0000_000B);
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("key9_single_commit", commit_cnt - start, 32'd1);
        check("key9_row_still", {28'b0, o_row}, 32'h0000_000B);
        release_key();
        cs_pulse();
        check("key9_ack", o_data, 32'h0000_0009);

        // ---- bouncing key 9 ----
        wait_row(4'b1011, "bounce_row2");
        exp_q.push_back(32'h0000_0109);
        start = commit_cnt;
        press(2'd2, 2'd1);
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 0) bounce_hi = ~bounce_hi;
            @(posedge clk);
            #1;
        end
        check("bounce_no_commit", commit_cnt - start, 32'd0);
        bounce_hi = 1'b0;
        wait_commit(start, "bounce_commit");
        repeat (40) @(posedge clk);
        #1;
        check("bounce_single_commit", commit_cnt - start, 32'd1);
        release_key();
        cs_pulse();
        check("bounce_ack", o_data, 32'h0000_0009);

        // ---- table-driven keys ----
        for (int v = 0; v < 4; v++) begin
            exp_q.push_back(vecs[v].exp_commit);
            start = commit_cnt;
            press(vecs[v].row, vecs[v].col);
            wait_commit(start, "table_commit");
            release_key();
            cs_pulse();
            check("table_ack", o_data, vecs[v].exp_ack);
        end

        // ---- overrun: key 3 then key C without a read ----
        exp_q.push_back(32'h0000_0103);
        start = commit_cnt;
        press(2'd0, 2'd3);
        wait_commit(start, "ovr_key3");
        release_key();
        exp_q.push_back(32'h0000_030C);
        start = commit_cnt;
        press(2'd3, 2'd0);
        wait_commit(start, "ovr_keyC");
        release_key();
        cs_pulse();
        check("ovr_ack", o_data, 32'h0000_000C);

        // ---- cs in the exact commit cycle while valid is set ----
        exp_q.push_back(32'h0000_010E);
        start = commit_cnt;
        press(2'd3, 2'd2);
        wait_commit(start, "pre_keyE");
        release_key();
        wait_row(4'b1110, "cs_row0");
        exp_q.push_back(32'h0000_0105);
        start = commit_cnt;
        press(2'd1, 2'd1);
        wait_row(4'b1101, "cs_row1");
        // Row visible -> 2 sync + 2 more to terminal sample + 8 debounce.
        repeat (11) @(posedge clk);
        #1 cs = 1'b1;
        @(posedge clk);
        #1 cs = 1'b0;
        wait_commit(start, "cs_commit");
        @(negedge clk);
        check("cs_commit_wins", o_data, 32'h0000_0105);
        release_key();

        // ---- reset during HOLD ----
        cs_pulse();
        check("pre_reset_ack", o_data, 32'h0000_0005);
        exp_q.push_back(32'h0000_0109);
        start = commit_cnt;
        press(2'd2, 2'd1);
        wait_commit(start, "hold_commit");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold_reset_row", {28'b0, o_row}, 32'h0000_000E);
        check("hold_reset_data", o_data, 32'h0);
        check("hold_reset_valid", {31'b0, o_valid}, 32'h0);
        exp_q.push_back(32'h0000_0109);
        start = commit_cnt;
        @(posedge clk);
        #1 reset = 1'b0;
        wait_commit(start, "redetect_commit");
        @(negedge clk);
        check("redetect_row", {28'b0, o_row}, 32'h0000_000B);
        release_key();

        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
